multi_pulse_gen: RTL

Multi-channel programmable pulse generator: each of CHANNELS independent channels emits single-cycle strobes on PULSE every DIV clocks (periodic mode) or once, DIV clocks after a trigger (one-shot mode). Divisors and modes are runtime-writable through a simple write port and take effect glitch-free at the next terminal count. It is the timebase source for the SRAM test and counter datapaths, replacing fixed-rate strobe generators so one instance serves all rate needs.

---
 rtl/multi_pulse_gen_if.sv | 33 +++
 rtl/multi_pulse_gen.sv | 93 +++++++++
 2 files changed

// File: rtl/multi_pulse_gen_if.sv
// multi_pulse_gen_if: configuration write port, enables/triggers and pulse/busy outputs.
// Carries SYNC only when MULTI_PULSE_GEN_SYNC_EN is defined.
interface multi_pulse_gen_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W = 16,
   parameter int CH_W = 2
);
   logic CFG_WE;
   logic [CH_W-1:0] CFG_CH;
   logic [CNT_W-1:0] CFG_DIV;
   logic CFG_MODE;
   logic [CHANNELS-1:0] EN;
   logic [CHANNELS-1:0] TRIG;
   logic [CHANNELS-1:0] PULSE;
   logic [CHANNELS-1:0] BUSY;
`ifdef MULTI_PULSE_GEN_SYNC_EN
   logic SYNC;
`endif
   modport master (
`ifdef MULTI_PULSE_GEN_SYNC_EN
      output SYNC,
`endif
      output CFG_WE, CFG_CH, CFG_DIV, CFG_MODE, EN, TRIG,
      input PULSE, BUSY
   );
   modport slave (
`ifdef MULTI_PULSE_GEN_SYNC_EN
      input SYNC,
`endif
      input CFG_WE, CFG_CH, CFG_DIV, CFG_MODE, EN, TRIG,
      output PULSE, BUSY
   );
endinterface

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: per-channel periodic/one-shot strobe generator with runtime divisors.
// MULTI_PULSE_GEN_SYNC_EN adds SYNC, which restarts the count of every running channel.
module multi_pulse_gen #(
   parameter int CHANNELS = 4,
   parameter int CNT_W = 16,
   parameter int CH_W = 2,
   parameter int DEFAULT_DIV = 100
) (
   input logic CLK,
   input logic RST,
   multi_pulse_gen_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q [CHANNELS];
   state_t state_d [CHANNELS];
   logic [CNT_W-1:0] cnt_q [CHANNELS];
   logic [CNT_W-1:0] cnt_d [CHANNELS];
   logic [CNT_W-1:0] sh_div_q [CHANNELS];
   logic [CNT_W-1:0] sh_div_d [CHANNELS];
   logic [CNT_W-1:0] act_div_q [CHANNELS];
   logic [CNT_W-1:0] act_div_d [CHANNELS];
   logic [CNT_W-1:0] eff [CHANNELS];
   logic [CHANNELS-1:0] sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
   logic [CHANNELS-1:0] pulse_q, pulse_d, busy, wr, term;
   logic sync;
`ifdef MULTI_PULSE_GEN_SYNC_EN
   assign sync = bus.SYNC;
`else
   assign sync = 1'b0;
`endif
   assign bus.PULSE = pulse_q;
   assign bus.BUSY = busy;
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         wr[i] = bus.CFG_WE && bus.CFG_CH == CH_W'(i);
         eff[i] = act_div_q[i] == '0 ? CNT_W'(1) : act_div_q[i];
         term[i] = cnt_q[i] == eff[i] - CNT_W'(1);
         busy[i] = state_q[i] == RUN;
         sh_div_d[i] = wr[i] ? bus.CFG_DIV : sh_div_q[i];
         sh_mode_d[i] = wr[i] ? bus.CFG_MODE : sh_mode_q[i];
         act_div_d[i] = act_div_q[i];
         act_mode_d[i] = act_mode_q[i];
         state_d[i] = state_q[i];
         cnt_d[i] = cnt_q[i];
         pulse_d[i] = 1'b0;
         if (state_q[i] == IDLE) begin
            act_div_d[i] = wr[i] ? bus.CFG_DIV : act_div_q[i];
            act_mode_d[i] = wr[i] ? bus.CFG_MODE : act_mode_q[i];
            if (bus.EN[i] && (!act_mode_q[i] || bus.TRIG[i])) begin
               state_d[i] = RUN;
               cnt_d[i] = '0;
            end
         end else if (!bus.EN[i]) begin
            state_d[i] = IDLE;
            cnt_d[i] = '0;
         end else if (sync) begin
            cnt_d[i] = '0;
         end else if (term[i]) begin
            // a write on this edge reaches active directly through the shadow bypass
            pulse_d[i] = 1'b1;
            cnt_d[i] = '0;
            act_div_d[i] = sh_div_d[i];
            act_mode_d[i] = sh_mode_d[i];
            state_d[i] = sh_mode_d[i] ? IDLE : RUN;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i] <= '0;
            sh_div_q[i] <= CNT_W'(DEFAULT_DIV);
            act_div_q[i] <= CNT_W'(DEFAULT_DIV);
         end
         sh_mode_q <= '0;
         act_mode_q <= '0;
         pulse_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i] <= cnt_d[i];
            sh_div_q[i] <= sh_div_d[i];
            act_div_q[i] <= act_div_d[i];
         end
         sh_mode_q <= sh_mode_d;
         act_mode_q <= act_mode_d;
         pulse_q <= pulse_d;
      end
   end
endmodule
